// File: rtl/err_metric_pkg.sv
// Shared types for the error-metric collector: metric selection and control FSM states.
package err_metric_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_MSE = 2'd0,
        MODE_MAE = 2'd1,
        MODE_MAX = 2'd2
    } metric_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        ACC,
        DRAIN,
        FINISH
    } state_t;

    // The reserved encoding falls back to mean squared error.
    function automatic metric_mode_t decode_mode(input logic [MODE_W-1:0] m);
        case (m)
            2'd1:    return MODE_MAE;
            2'd2:    return MODE_MAX;
            default: return MODE_MSE;
        endcase
    endfunction

endpackage

// File: rtl/err_metric_pe.sv
// Difference / magnitude / square of one sample pair, registered once with its valid bit.
module err_metric_pe #(
    parameter int DATA_WL = 12,
    parameter int SIGNED  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld_p0,
    input  logic [DATA_WL-1:0]     data_in,
    input  logic [DATA_WL-1:0]     data_ref,
    output logic                   vld_p1,
    output logic [DATA_WL:0]       absd_p1,
    output logic [2*DATA_WL+1:0]   sq_p1
);

    localparam int SQ_W = 2*DATA_WL + 2;

    logic signed [DATA_WL:0] a_ext;
    logic signed [DATA_WL:0] b_ext;
    logic signed [DATA_WL:0] diff;
    logic        [DATA_WL:0] absd;
    logic        [SQ_W-1:0]  sq;

    // One extra bit holds any difference of two DATA_WL-bit operands, so the negation cannot wrap.
    function automatic logic [DATA_WL:0] abs_val(input logic signed [DATA_WL:0] d);
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    assign a_ext = (SIGNED != 0) ? {data_in[DATA_WL-1], data_in}   : {1'b0, data_in};
    assign b_ext = (SIGNED != 0) ? {data_ref[DATA_WL-1], data_ref} : {1'b0, data_ref};
    assign diff  = a_ext - b_ext;
    assign absd  = abs_val(diff);
    assign sq    = SQ_W'(absd) * SQ_W'(absd);

    // p0 -> p1
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
        absd_p1 <= absd;
        sq_p1   <= sq;
    end

endmodule

// File: rtl/err_metric_collector.sv
// Windowed MSE / MAE / max-abs error between DUT and reference streams, with warm-up skip.
module err_metric_collector
    import err_metric_pkg::*;
#(
    parameter int DATA_WL  = 12,
    parameter int SIGNED   = 1,
    parameter int ACC_WL   = 64,
    parameter int MAX_LOG2 = 20,
    parameter int SKIP_WL  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MODE_W-1:0]  mode,
    input  logic [4:0]         n_log2,
    input  logic [SKIP_WL-1:0] skip,
    input  logic               in_valid,
    input  logic [DATA_WL-1:0] data_in,
    input  logic [DATA_WL-1:0] data_ref,
    output logic               busy,
    output logic [ACC_WL-1:0]  data_out,
    output logic               data_valid,
    output logic               overflow
);

    localparam int SQ_W  = 2*DATA_WL + 2;
    localparam int SUM_W = ((ACC_WL > SQ_W) ? ACC_WL : SQ_W) + 1;
    localparam int CNT_W = MAX_LOG2 + 1;
    localparam logic [4:0] MAX_N = 5'(MAX_LOG2);

    state_t             state;
    metric_mode_t       mode_q;
    logic [4:0]         nlog_q;
    logic [SKIP_WL-1:0] skip_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   window;
    logic [ACC_WL-1:0]  acc;

    logic               vld_p0;
    logic               vld_p1;
    logic [DATA_WL:0]   absd_p1;
    logic [SQ_W-1:0]    sq_p1;
    logic               clear;
    logic [SUM_W-1:0]   addend;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   absd_w;

    function automatic logic [4:0] clamp_log2(input logic [4:0] n);
        return (n > MAX_N) ? MAX_N : n;
    endfunction

    function automatic logic sum_ovf(input logic [SUM_W-1:0] s);
        return |s[SUM_W-1:ACC_WL];
    endfunction

    function automatic logic [ACC_WL-1:0] sat_acc(input logic [SUM_W-1:0] s);
        return sum_ovf(s) ? {ACC_WL{1'b1}} : s[ACC_WL-1:0];
    endfunction

    function automatic logic [ACC_WL-1:0] result(input metric_mode_t m, input logic [ACC_WL-1:0] a,
                                                 input logic [4:0] n);
        return (m == MODE_MAX) ? a : (a >> n);
    endfunction

    assign window = CNT_W'(1) << nlog_q;
    assign clear  = (state == IDLE) && start;
    // cnt stops at window, so samples arriving after the last push are dropped
    assign vld_p0 = (state == ACC) && in_valid && (cnt != window);
    assign addend = (mode_q == MODE_MAE) ? SUM_W'(absd_p1) : SUM_W'(sq_p1);
    assign sum    = SUM_W'(acc) + addend;
    assign absd_w = SUM_W'(absd_p1);

    err_metric_pe #(
        .DATA_WL (DATA_WL),
        .SIGNED  (SIGNED)
    ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .vld_p0   (vld_p0),
        .data_in  (data_in),
        .data_ref (data_ref),
        .vld_p1   (vld_p1),
        .absd_p1  (absd_p1),
        .sq_p1    (sq_p1)
    );

    // p1 -> p2: accumulator
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (vld_p1) begin
            if (mode_q == MODE_MAX) begin
                if (absd_w > SUM_W'(acc)) begin
                    acc <= sat_acc(absd_w);
                end
            end else begin
                acc <= sat_acc(sum);
                if (sum_ovf(sum)) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            mode_q     <= MODE_MSE;
            nlog_q     <= '0;
            skip_cnt   <= '0;
            cnt        <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= decode_mode(mode);
                        nlog_q   <= clamp_log2(n_log2);
                        skip_cnt <= skip;
                        cnt      <= '0;
                        data_out <= '0;
                        busy     <= 1'b1;
                        state    <= (skip != '0) ? SKIP : ACC;
                    end
                end
                SKIP: begin
                    if (in_valid) begin
                        skip_cnt <= skip_cnt - 1'b1;
                        if (skip_cnt == SKIP_WL'(1)) begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (vld_p0) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cnt == window) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= FINISH;
                end
                FINISH: begin
                    data_out   <= result(mode_q, acc, nlog_q);
                    data_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_err_metric_collector.sv
// Bench for err_metric_collector: vector table plus scoreboard queue, with hand-written corner sequences.
module tb_err_metric_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [4:0]  n_log2 = '0;
    logic [7:0]  skip = '0;
    logic        in_valid = 1'b0;
    logic [11:0] data_in = '0;
    logic [11:0] data_ref = '0;

    logic        busy;
    logic [63:0] data_out;
    logic        data_valid;
    logic        overflow;

    logic        s_busy;
    logic [15:0] s_data_out;
    logic        s_data_valid;
    logic        s_overflow;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_cyc = 0;
    int s_vcnt = 0;
    bit lat_chk = 1'b1;

    typedef struct {
        logic [63:0] dout;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  nlog;
        logic [7:0]  skip;
        logic [11:0] skip_in;
        logic [11:0] skip_ref;
        logic [11:0] win_in  [4];
        logic [11:0] win_ref [4];
        int          gap;
        logic [63:0] exp_dout;
        logic        exp_ov;
        bit          s_chk;
        logic [15:0] s_dout;
        logic        s_ov;
    } vec_t;

    vec_t vecs[12];

    err_metric_collector dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .n_log2     (n_log2),
        .skip       (skip),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .data_ref   (data_ref),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overflow   (overflow)
    );

    err_metric_collector #(
        .DATA_WL  (12),
        .SIGNED   (0),
        .ACC_WL   (16),
        .MAX_LOG2 (20),
        .SKIP_WL  (8)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .n_log2     (n_log2),
        .skip       (skip),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .data_ref   (data_ref),
        .busy       (s_busy),
        .data_out   (s_data_out),
        .data_valid (s_data_valid),
        .overflow   (s_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (!rst && s_data_valid) s_vcnt <= s_vcnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every data_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && data_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_data_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data_out", data_out, e.dout);
                chk("overflow", {63'd0, overflow}, {63'd0, e.ov});
                chk("busy_at_valid", {63'd0, busy}, 64'd0);
                if (lat_chk) chk("latency", 64'(cyc - last_cyc), 64'd3);
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] m, input logic [4:0] n, input logic [7:0] sk,
                                input logic [11:0] si, input logic [11:0] sr,
                                input logic [11:0] i0, input logic [11:0] r0,
                                input logic [11:0] i1, input logic [11:0] r1,
                                input logic [11:0] i2, input logic [11:0] r2,
                                input logic [11:0] i3, input logic [11:0] r3,
                                input int g, input logic [63:0] ed, input logic eo,
                                input bit sc, input logic [15:0] sd, input logic so);
        vec_t v;
        v.mode = m; v.nlog = n; v.skip = sk; v.skip_in = si; v.skip_ref = sr;
        v.win_in[0] = i0; v.win_ref[0] = r0; v.win_in[1] = i1; v.win_ref[1] = r1;
        v.win_in[2] = i2; v.win_ref[2] = r2; v.win_in[3] = i3; v.win_ref[3] = r3;
        v.gap = g; v.exp_dout = ed; v.exp_ov = eo; v.s_chk = sc; v.s_dout = sd; v.s_ov = so;
        return v;
    endfunction

    task automatic drive(input logic [11:0] di, input logic [11:0] dr, input int gap);
        in_valid = 1'b1;
        data_in  = di;
        data_ref = dr;
        last_cyc = cyc + 1;
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            start    = 1'b1;
            repeat (gap) @(negedge clk);
            start    = 1'b0;
        end
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   s0;
        s0 = s_vcnt;
        @(negedge clk);
        mode = v.mode; n_log2 = v.nlog; skip = v.skip; start = 1'b1; in_valid = 1'b0;
        e.dout = v.exp_dout; e.ov = v.exp_ov;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("data_out_cleared", data_out, 64'd0);
        for (int i = 0; i < int'(v.skip); i++) drive(v.skip_in, v.skip_ref, v.gap);
        for (int i = 0; i < (1 << v.nlog); i++) drive(v.win_in[i % 4], v.win_ref[i % 4], v.gap);
        in_valid = 1'b0;
        wait_empty("result_timeout");
        repeat (2) @(negedge clk);
        chk("data_out_held", data_out, v.exp_dout);
        if (v.s_chk) begin
            chk("narrow_data_out", 64'(s_data_out), 64'(v.s_dout));
            chk("narrow_overflow", {63'd0, s_overflow}, {63'd0, v.s_ov});
            chk("narrow_one_pulse", 64'(s_vcnt - s0), 64'd1);
            chk("narrow_busy", {63'd0, s_busy}, 64'd0);
        end
    endtask

    initial begin
        exp_t e;
        vecs[0]  = mk(2'd0, 5'd2, 8'd0, 12'd0, 12'd0, 12'd10, 12'd7, 12'd10, 12'd7,
                      12'd10, 12'd7, 12'd10, 12'd7, 0, 64'd9, 1'b0, 1'b0, 16'd0, 1'b0);
        vecs[1]  = mk(2'd0, 5'd1, 8'd5, 12'd100, 12'd0, 12'd9, 12'd7, 12'd9, 12'd7,
                      12'd9, 12'd7, 12'd9, 12'd7, 0, 64'd4, 1'b0, 1'b0, 16'd0, 1'b0);
        vecs[2]  = mk(2'd2, 5'd2, 8'd0, 12'd0, 12'd0, 12'd0, 12'd50, 12'd20, 12'd0,
                      12'd30, 12'd0, 12'd0, 12'd10, 0, 64'd50, 1'b0, 1'b0, 16'd0, 1'b0);
        vecs[3]  = mk(2'd1, 5'd2, 8'd0, 12'd0, 12'd0, 12'd0, 12'd50, 12'd20, 12'd0,
                      12'd30, 12'd0, 12'd0, 12'd10, 0, 64'd27, 1'b0, 1'b0, 16'd0, 1'b0);
        vecs[4]  = mk(2'd3, 5'd2, 8'd0, 12'd0, 12'd0, 12'd10, 12'd7, 12'd10, 12'd7,
                      12'd10, 12'd7, 12'd10, 12'd7, 0, 64'd9, 1'b0, 1'b0, 16'd0, 1'b0);
        vecs[5]  = mk(2'd0, 5'd0, 8'd0, 12'd0, 12'd0, 12'd3, 12'd10, 12'd3, 12'd10,
                      12'd3, 12'd10, 12'd3, 12'd10, 0, 64'd49, 1'b0, 1'b0, 16'd0, 1'b0);
        vecs[6]  = mk(2'd0, 5'd2, 8'd0, 12'd0, 12'd0, 12'd10, 12'd7, 12'd10, 12'd7,
                      12'd10, 12'd7, 12'd10, 12'd7, 1, 64'd9, 1'b0, 1'b0, 16'd0, 1'b0);
        vecs[7]  = mk(2'd1, 5'd3, 8'd0, 12'd0, 12'd0, 12'd5, 12'd0, 12'd0, 12'd3,
                      12'd7, 12'd7, 12'd0, 12'd100, 0, 64'd27, 1'b0, 1'b0, 16'd0, 1'b0);
        // 4095 is -1 in the signed instance and full-scale in the unsigned narrow one.
        vecs[8]  = mk(2'd0, 5'd4, 8'd0, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd4095, 12'd0,
                      12'd4095, 12'd0, 12'd4095, 12'd0, 0, 64'd1, 1'b0, 1'b1, 16'd4095, 1'b1);
        vecs[9]  = mk(2'd2, 5'd0, 8'd0, 12'd0, 12'd0, 12'd2047, 12'h800, 12'd2047, 12'h800,
                      12'd2047, 12'h800, 12'd2047, 12'h800, 0, 64'd4095, 1'b0, 1'b1, 16'd1, 1'b0);
        vecs[10] = mk(2'd0, 5'd0, 8'd0, 12'd0, 12'd0, 12'd2047, 12'h800, 12'd2047, 12'h800,
                      12'd2047, 12'h800, 12'd2047, 12'h800, 0, 64'd16769025, 1'b0, 1'b1, 16'd1, 1'b0);
        vecs[11] = mk(2'd0, 5'd1, 8'd3, 12'd100, 12'd0, 12'd9, 12'd7, 12'd9, 12'd7,
                      12'd9, 12'd7, 12'd9, 12'd7, 2, 64'd4, 1'b0, 1'b0, 16'd0, 1'b0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_data_out", data_out, 64'd0);
        chk("reset_data_valid", {63'd0, data_valid}, 64'd0);
        chk("reset_overflow", {63'd0, overflow}, 64'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset during accumulation aborts the run without a result.
        @(negedge clk);
        mode = 2'd0; n_log2 = 5'd2; skip = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(12'd10, 12'd7, 0);
        drive(12'd10, 12'd7, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_data_out", data_out, 64'd0);
        chk("abort_data_valid", {63'd0, data_valid}, 64'd0);
        repeat (10) @(negedge clk);
        chk("abort_still_idle", {63'd0, busy}, 64'd0);
        run_vec(vecs[0]);

        // Start held high: a new run begins right after the previous one finishes.
        @(negedge clk);
        lat_chk = 1'b0;
        mode = 2'd0; n_log2 = 5'd0; skip = 8'd0; start = 1'b1;
        in_valid = 1'b1; data_in = 12'd3; data_ref = 12'd0;
        e.dout = 64'd9; e.ov = 1'b0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int n = 0; n < 40 && exp_q.size() > 1; n++) @(negedge clk);
        chk("restart_first_result", 64'(exp_q.size()), 64'd1);
        @(negedge clk);
        chk("restart_busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
        wait_empty("restart_timeout");
        in_valid = 1'b0;
        lat_chk = 1'b1;
        repeat (6) @(negedge clk);
        chk("final_idle", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
